// File: rtl/exec_pkg.sv
// Shared definitions for the execute sequencer: ALU operation codes,
// sequencer state encodings and latency-class helpers.
package exec_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_AND     = 4'b0010;
  localparam logic [3:0] ALU_ORR     = 4'b0011;
  localparam logic [3:0] ALU_MUL     = 4'b0100;
  localparam logic [3:0] ALU_UMULL   = 4'b0101;
  localparam logic [3:0] ALU_SMULL   = 4'b0110;
  localparam logic [3:0] ALU_DIV     = 4'b0111;
  localparam logic [3:0] ALU_FPADD32 = 4'b1000;
  localparam logic [3:0] ALU_FPADD16 = 4'b1001;
  localparam logic [3:0] ALU_FPMUL32 = 4'b1010;
  localparam logic [3:0] ALU_MOV     = 4'b1011;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_WB_LO = 3'd2,
    ST_WB_HI = 3'd3
  } state_t;

  // Long multiplies produce two result words (RdLo then RdHi).
  function automatic logic is_long(input logic [3:0] op);
    return (op == ALU_UMULL) || (op == ALU_SMULL);
  endfunction

  // Number of execute cycles for an operation, given the unit latencies.
  function automatic int lat_of(input logic [3:0] op, input int mul_lat,
                                input int div_lat, input int fp_lat);
    case (op)
      ALU_MUL, ALU_UMULL, ALU_SMULL:       return mul_lat;
      ALU_DIV:                             return div_lat;
      ALU_FPADD32, ALU_FPADD16, ALU_FPMUL32: return fp_lat;
      default:                             return 1;
    endcase
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Handshake/writeback bundle between the main FSM (master) and the
// execute sequencer (slave). Optional perf counters appear when
// EXEC_SEQ_PERF_EN is defined.
interface exec_sequencer_if;
  logic       start;
  logic [3:0] ALUControl;
  logic [1:0] FlagWIn;
  logic       CondEx;
  logic [3:0] RdLo;
  logic [3:0] RdHi;
  logic       abort;
  logic       busy;
  logic       stall;
  logic       RegW;
  logic [3:0] WA3;
  logic       ResultHi;
  logic [1:0] FlagW;
  logic       done;
  logic [2:0] state;
`ifdef EXEC_SEQ_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] ops_retired;
`endif

  modport master (
    output start, ALUControl, FlagWIn, CondEx, RdLo, RdHi, abort,
    input  busy, stall, RegW, WA3, ResultHi, FlagW, done, state
`ifdef EXEC_SEQ_PERF_EN
    , input stall_cycles, ops_retired
`endif
  );

  modport slave (
    input  start, ALUControl, FlagWIn, CondEx, RdLo, RdHi, abort,
    output busy, stall, RegW, WA3, ResultHi, FlagW, done, state
`ifdef EXEC_SEQ_PERF_EN
    , output stall_cycles, ops_retired
`endif
  );
endinterface

// File: rtl/exec_sequencer_lat_counter.sv
// Execute-latency down-counter: loaded with L-1 on issue, counts down to
// zero while the operation runs.
module lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load takes priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - CNT_W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle execute controller: stalls the main FSM while an operation
// runs, then issues one (or two, for long multiply) writeback cycles.
// Optional perf counters are enabled by defining EXEC_SEQ_PERF_EN.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8,
  parameter int FP_LAT  = 3,
  parameter int CNT_W   = 4
) (
  input logic              clk,
  input logic              reset,
  exec_sequencer_if.slave  bus
);

  state_t           state;
  logic [3:0]       alu_l;
  logic [1:0]       flagw_l;
  logic             cond_l;
  logic [3:0]       rdlo_l;
  logic [3:0]       rdhi_l;
  logic             regw_q;
  logic [3:0]       wa3_q;
  logic             resulthi_q;
  logic [1:0]       flagw_q;
  logic             done_q;
  logic             accept;
  logic             cnt_zero;
  logic             kill;
  logic [CNT_W-1:0] load_val;

  assign accept   = (state == ST_IDLE) && bus.start && !bus.abort;
  assign load_val = CNT_W'(lat_of(bus.ALUControl, MUL_LAT, DIV_LAT, FP_LAT) - 1);
  assign kill     = bus.abort | reset;

  lat_counter #(.CNT_W(CNT_W)) u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .dec      (state == ST_EXEC),
    .load_val (load_val),
    .zero     (cnt_zero)
  );

  // Sequencer FSM: latches the op on issue and registers the writeback strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      alu_l      <= '0;
      flagw_l    <= '0;
      cond_l     <= 1'b0;
      rdlo_l     <= '0;
      rdhi_l     <= '0;
      regw_q     <= 1'b0;
      wa3_q      <= '0;
      resulthi_q <= 1'b0;
      flagw_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      regw_q     <= 1'b0;
      resulthi_q <= 1'b0;
      flagw_q    <= '0;
      done_q     <= 1'b0;
      if (bus.abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              alu_l   <= bus.ALUControl;
              flagw_l <= bus.FlagWIn;
              cond_l  <= bus.CondEx;
              rdlo_l  <= bus.RdLo;
              rdhi_l  <= bus.RdHi;
              state   <= ST_EXEC;
            end
          end
          ST_EXEC: begin
            if (cnt_zero) begin
              state  <= ST_WB_LO;
              regw_q <= cond_l;
              wa3_q  <= rdlo_l;
              if (!is_long(alu_l)) begin
                flagw_q <= flagw_l & {2{cond_l}};
                done_q  <= 1'b1;
              end
            end
          end
          ST_WB_LO: begin
            if (is_long(alu_l)) begin
              state      <= ST_WB_HI;
              regw_q     <= cond_l;
              wa3_q      <= rdhi_l;
              resulthi_q <= 1'b1;
              flagw_q    <= flagw_l & {2{cond_l}};
              done_q     <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy     = (state != ST_IDLE);
  assign bus.stall    = (state != ST_IDLE) | bus.start;
  assign bus.RegW     = regw_q & ~kill;
  assign bus.FlagW    = flagw_q & {2{~kill}};
  assign bus.done     = done_q & ~kill;
  assign bus.WA3      = wa3_q;
  assign bus.ResultHi = resulthi_q;
  assign bus.state    = state;

`ifdef EXEC_SEQ_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] retired_q;

  // Saturating counters of busy cycles and of retired (non-aborted) ops.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q   <= '0;
      retired_q <= '0;
    end else begin
      if ((state != ST_IDLE) && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
      if (bus.done && (retired_q != '1))
        retired_q <= retired_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.ops_retired  = retired_q;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: a scoreboard of expected
// writeback cycles is filled at issue and drained as the DUT writes back.
module tb_exec_sequencer;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 8;
  localparam int FP_LAT  = 3;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic       regw;
    logic [3:0] wa3;
    logic       resulthi;
    logic [1:0] flagw;
    logic       done;
  } wb_t;

  logic clk = 1'b0;
  logic reset;
  wb_t  sb[$];
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  exec_sequencer_if bus ();

  exec_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .FP_LAT  (FP_LAT),
    .CNT_W   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic int model_lat(input logic [3:0] op);
    case (op)
      4'b0100, 4'b0101, 4'b0110: return MUL_LAT;
      4'b0111:                   return DIV_LAT;
      4'b1000, 4'b1001, 4'b1010: return FP_LAT;
      default:                   return 1;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, push its expected writebacks, then follow it to IDLE.
  task automatic apply_stimulus(input logic [3:0] op, input logic [1:0] fwin,
                                input logic cond, input logic [3:0] rdlo,
                                input logic [3:0] rdhi, input bit noise);
    int  l;
    int  last;
    bit  lng;
    wb_t e;
    l    = model_lat(op);
    lng  = (op == 4'b0101) || (op == 4'b0110);
    last = l + 1 + int'(lng);
    e.cyc = l + 1; e.st = 3'd2; e.regw = cond; e.wa3 = rdlo; e.resulthi = 1'b0;
    e.flagw = lng ? 2'b00 : (fwin & {2{cond}}); e.done = !lng;
    sb.push_back(e);
    if (lng) begin
      e.cyc = l + 2; e.st = 3'd3; e.regw = cond; e.wa3 = rdhi; e.resulthi = 1'b1;
      e.flagw = fwin & {2{cond}}; e.done = 1'b1;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.ALUControl = op; bus.FlagWIn = fwin;
    bus.CondEx = cond; bus.RdLo = rdlo; bus.RdHi = rdhi;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= last + 1; cyc++) begin
      check_output($sformatf("busy_c%0d", cyc), bus.busy, (cyc <= last));
      check_output($sformatf("stall_c%0d", cyc), bus.stall, (cyc <= last) || bus.start);
      if (bus.state == 3'd2 || bus.state == 3'd3) begin
        if (sb.size() == 0) begin
          check_output("unexpected_wb", 1, 0);
        end else begin
          e = sb.pop_front();
          check_output("wb_cycle", cyc, e.cyc);
          check_output("wb_state", bus.state, e.st);
          check_output("wb_regw", bus.RegW, e.regw);
          check_output("wb_wa3", bus.WA3, e.wa3);
          check_output("wb_resulthi", bus.ResultHi, e.resulthi);
          check_output("wb_flagw", bus.FlagW, e.flagw);
          check_output("wb_done", bus.done, e.done);
        end
      end else begin
        check_output($sformatf("quiet_c%0d", cyc), {bus.RegW, bus.FlagW, bus.done}, 0);
      end
      if (cyc == last + 1) break;
      @(negedge clk);
      bus.start = 1'b0;
      if (noise && cyc == 2) begin
        bus.start = 1'b1; bus.ALUControl = 4'b0000; bus.RdLo = 4'd1; bus.RdHi = 4'd1;
      end
      @(posedge clk); #1;
    end
    check_output("sb_drained", sb.size(), 0);
    sb.delete();
    bus.start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.ALUControl = '0; bus.FlagWIn = '0; bus.CondEx = 1'b0;
    bus.RdLo = '0; bus.RdHi = '0; bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_state", bus.state, 0);
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_stall", bus.stall, 0);
    check_output("rst_strobes", {bus.RegW, bus.ResultHi, bus.FlagW, bus.done}, 0);
    check_output("rst_wa3", bus.WA3, 0);
    @(negedge clk);
    reset = 1'b0;

    apply_stimulus(4'b0000, 2'b11, 1'b1, 4'd3, 4'd0, 1'b0);
    apply_stimulus(4'b0111, 2'b00, 1'b1, 4'd5, 4'd0, 1'b1);
    apply_stimulus(4'b0101, 2'b10, 1'b1, 4'd2, 4'd7, 1'b0);
    apply_stimulus(4'b0110, 2'b11, 1'b0, 4'd4, 4'd9, 1'b0);
    apply_stimulus(4'b0100, 2'b01, 1'b1, 4'd8, 4'd0, 1'b0);
    apply_stimulus(4'b1010, 2'b11, 1'b1, 4'd10, 4'd0, 1'b0);
    apply_stimulus(4'b0101, 2'b01, 1'b1, 4'd6, 4'd6, 1'b0);

    // FPADD32 aborted in its second EXEC cycle, with a start while busy.
    @(negedge clk);
    bus.start = 1'b1; bus.ALUControl = 4'b1000; bus.FlagWIn = 2'b11;
    bus.CondEx = 1'b1; bus.RdLo = 4'd9;
    @(posedge clk); #1;
    check_output("abort_exec1", bus.state, 1);
    @(negedge clk);
    bus.start = 1'b1; bus.ALUControl = 4'b0000; bus.RdLo = 4'd1;
    @(posedge clk); #1;
    check_output("start_busy_ignored", bus.state, 1);
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b1;
    @(posedge clk); #1;
    check_output("abort_idle", bus.state, 0);
    check_output("abort_busy", bus.busy, 0);
    check_output("abort_strobes", {bus.RegW, bus.FlagW, bus.done}, 0);
    @(negedge clk);
    bus.abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_output($sformatf("abort_quiet_%0d", i), {bus.state, bus.RegW, bus.done}, 0);
    end

    // abort gates the writeback strobes in the same cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.ALUControl = 4'b0000; bus.FlagWIn = 2'b11;
    bus.CondEx = 1'b1; bus.RdLo = 4'd4;
    @(posedge clk); #1;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check_output("gate_pre_regw", {bus.RegW, bus.FlagW, bus.done}, 4'b1111);
    bus.abort = 1'b1;
    #1;
    check_output("gate_abort", {bus.RegW, bus.FlagW, bus.done}, 0);
    @(negedge clk);
    bus.abort = 1'b0;
    @(posedge clk); #1;
    check_output("gate_after_idle", bus.state, 0);

    // Reset during WB_HI of a long multiply.
    @(negedge clk);
    bus.start = 1'b1; bus.ALUControl = 4'b0101; bus.FlagWIn = 2'b11;
    bus.CondEx = 1'b1; bus.RdLo = 4'd2; bus.RdHi = 4'd3;
    @(posedge clk); #1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rstwb_state", bus.state, 3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_output("rstwb_gate", {bus.RegW, bus.FlagW, bus.done}, 0);
    @(posedge clk); #1;
    check_output("rstwb_idle", bus.state, 0);
    check_output("rstwb_busy", bus.busy, 0);
    check_output("rstwb_strobes", {bus.RegW, bus.ResultHi, bus.FlagW, bus.done}, 0);
    check_output("rstwb_wa3", bus.WA3, 0);
`ifdef EXEC_SEQ_PERF_EN
    check_output("rstwb_stall_cycles", bus.stall_cycles, 0);
    check_output("rstwb_ops_retired", bus.ops_retired, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_output("post_reset_idle", bus.state, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
